// File: rtl/restador_serie_no_signo.sv
// restador_serie_no_signo: bit-serial unsigned subtractor, LSB first, one result every ANCHO cycles.
// Ports:
//   clk          - clock, all state updates on the rising edge
//   reset        - synchronous active-high reset
//   Inicio       - start request, accepted while idle (including the Listo cycle)
//   MinuendoA    - unsigned minuend, captured on the accepting edge
//   SustraendoB  - unsigned subtrahend, captured on the accepting edge
//   Diferencia   - registered (A - B) mod 2^ANCHO, updated only on completion
//   Prestamo     - registered final borrow, 1 iff A < B
//   Ocupado      - high while bits are still being processed
//   Listo        - one-cycle pulse marking fresh Diferencia/Prestamo
module restador_serie_no_signo #(
    parameter int ANCHO = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Inicio,
    input  logic [ANCHO-1:0] MinuendoA,
    input  logic [ANCHO-1:0] SustraendoB,
    output logic [ANCHO-1:0] Diferencia,
    output logic             Prestamo,
    output logic             Ocupado,
    output logic             Listo
);
    localparam int WC = $clog2(ANCHO + 1);

    typedef enum logic {REPOSO, RESTANDO} estado_t;

    estado_t          r_estado, w_siguiente;
    logic [ANCHO-1:0] r_a, r_b, r_res, r_dif;
    logic [WC-1:0]    r_cnt;
    logic             r_bin, r_pre, r_listo;
    logic             w_acepta, w_ultimo, w_d, w_bout, w_d0, w_b0;
    logic [ANCHO-1:0] w_res;

    assign w_acepta = (r_estado == REPOSO) && Inicio;
    assign w_ultimo = (r_estado == RESTANDO) && (r_cnt == WC'(1));
    assign w_d      = r_a[0] ^ r_b[0] ^ r_bin;
    assign w_bout   = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bin);
    assign w_res    = {w_d, r_res[ANCHO-1:1]};
    // Bit 0 is resolved on the accepting edge itself (borrow-in is zero there),
    // so the remaining ANCHO-1 bits finish in time for Listo to land in the
    // ANCHO-th cycle and a start during Listo gives gap-free back-to-back runs.
    assign w_d0     = MinuendoA[0] ^ SustraendoB[0];
    assign w_b0     = ~MinuendoA[0] & SustraendoB[0];

    assign Diferencia = r_dif;
    assign Prestamo   = r_pre;
    assign Listo      = r_listo;
    assign Ocupado    = (r_estado == RESTANDO);

    always_comb begin
        w_siguiente = r_estado;
        if (w_acepta)
            w_siguiente = RESTANDO;
        else if (w_ultimo)
            w_siguiente = REPOSO;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_estado <= REPOSO;
        else
            r_estado <= w_siguiente;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            r_dif   <= '0;
            r_pre   <= 1'b0;
            r_listo <= 1'b0;
        end else begin
            r_listo <= w_ultimo;
            if (w_acepta) begin
                r_a   <= MinuendoA >> 1;
                r_b   <= SustraendoB >> 1;
                r_res <= {w_d0, {(ANCHO-1){1'b0}}};
                r_bin <= w_b0;
                r_cnt <= WC'(ANCHO - 1);
            end else if (r_estado == RESTANDO) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_res <= w_res;
                r_bin <= w_bout;
                r_cnt <= r_cnt - WC'(1);
                if (w_ultimo) begin
                    r_dif <= w_res;
                    r_pre <= w_bout;
                end
            end
        end
    end
endmodule

// File: tb/tb_restador_serie_no_signo.sv
// tb_restador_serie_no_signo: directed + exhaustive scoreboard bench for the serial subtractor.
module tb_restador_serie_no_signo;
    localparam int ANCHO = 4;

    logic             clk = 1'b0;
    logic             reset, Inicio;
    logic [ANCHO-1:0] MinuendoA, SustraendoB, Diferencia;
    logic             Prestamo, Ocupado, Listo;

    int total = 0;
    int bad = 0;
    int n_listo = 0;
    int n_push = 0;
    logic [ANCHO:0] sb[$];

    restador_serie_no_signo #(.ANCHO(ANCHO)) dut (
        .clk(clk), .reset(reset), .Inicio(Inicio),
        .MinuendoA(MinuendoA), .SustraendoB(SustraendoB),
        .Diferencia(Diferencia), .Prestamo(Prestamo),
        .Ocupado(Ocupado), .Listo(Listo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [ANCHO:0] golden(input int a, input int b);
        int d;
        d = a - b;
        return {logic'(a < b), ANCHO'(d & ((1 << ANCHO) - 1))};
    endfunction

    task automatic push(input int a, input int b);
        sb.push_back(golden(a, b));
        n_push++;
    endtask

    // Scoreboard consumer: every Listo pulse must match the oldest pending request.
    always @(negedge clk) begin
        if (Listo === 1'b1) begin
            n_listo++;
            if (sb.size() == 0) begin
                chk("listo_sin_pedido", 1, 0);
            end else begin
                logic [ANCHO:0] e;
                e = sb.pop_front();
                chk("diferencia", int'(Diferencia), int'(e[ANCHO-1:0]));
                chk("prestamo", int'(Prestamo), int'(e[ANCHO]));
                chk("ocupado_en_listo", int'(Ocupado), 0);
            end
        end
    end

    task automatic start(input int a, input int b);
        Inicio = 1'b1;
        MinuendoA = ANCHO'(a);
        SustraendoB = ANCHO'(b);
        push(a, b);
        @(posedge clk);
        #1;
        Inicio = 1'b0;
        MinuendoA = ANCHO'($urandom);
        SustraendoB = ANCHO'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_listo", int'(sb.size()), 0);
        @(negedge clk);
    endtask

    initial begin
        int base;
        reset = 1'b1;
        Inicio = 1'b0;
        MinuendoA = '0;
        SustraendoB = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_dif", int'(Diferencia), 0);
        chk("rst_pre", int'(Prestamo), 0);
        chk("rst_ocu", int'(Ocupado), 0);
        chk("rst_lis", int'(Listo), 0);

        // 9-3: Listo in the 4th cycle after accept, Ocupado for the 3 before it
        @(posedge clk);
        #1;
        start(9, 3);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t_ocupado", int'(Ocupado), int'(i < 4));
            chk("t_listo", int'(Listo), int'(i == 4));
        end
        repeat (3) @(negedge clk);
        chk("hold_dif", int'(Diferencia), 6);
        chk("hold_lis", int'(Listo), 0);

        @(posedge clk);
        #1;
        start(3, 9);
        wait_idle();
        start(0, 1);
        wait_idle();
        start(15, 15);
        wait_idle();

        // Start while busy is ignored
        base = n_listo;
        start(12, 5);
        @(posedge clk);
        #1;
        Inicio = 1'b1;
        MinuendoA = 4'd1;
        SustraendoB = 4'd2;
        @(posedge clk);
        #1;
        Inicio = 1'b0;
        repeat (8) @(negedge clk);
        chk("ignorado_un_listo", n_listo - base, 1);
        chk("ignorado_dif", int'(Diferencia), 7);

        // Reset during the 2nd bit cycle aborts without Listo; restart right after
        @(posedge clk);
        #1;
        Inicio = 1'b1;
        MinuendoA = 4'd8;
        SustraendoB = 4'd1;
        @(posedge clk);
        #1;
        Inicio = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        base = n_listo;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_dif", int'(Diferencia), 0);
        chk("abort_pre", int'(Prestamo), 0);
        chk("abort_ocu", int'(Ocupado), 0);
        chk("abort_lis", int'(Listo), 0);
        repeat (6) @(negedge clk);
        chk("abort_sin_listo", n_listo - base, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start(8, 1);
        wait_idle();
        chk("post_rst_un_listo", n_listo - base, 1);

        // Inicio held high: (5,2) then (2,5), Listo every 4 cycles
        @(posedge clk);
        #1;
        Inicio = 1'b1;
        MinuendoA = 4'd5;
        SustraendoB = 4'd2;
        push(5, 2);
        @(posedge clk);
        #1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("cont_listo", int'(Listo), int'(i == 4 || i == 8));
            if (i < 4) begin
                MinuendoA = ANCHO'($urandom);
                SustraendoB = ANCHO'($urandom);
            end
            if (i == 4) begin
                MinuendoA = 4'd2;
                SustraendoB = 4'd5;
                push(2, 5);
            end
            if (i == 5) Inicio = 1'b0;
        end
        wait_idle();

        // Exhaustive back-to-back sweep, each start lands in the previous Listo cycle
        @(posedge clk);
        #1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start(a, b);
                repeat (ANCHO - 1) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        chk("sb_vacio", int'(sb.size()), 0);
        chk("listo_vs_pedidos", n_listo, n_push);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
